// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, ALU operation classes and ALU control codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's operation class plus the R-type funct
// field onto the 3-bit ALU control code. Purely combinational.
module mc_aludec
    import mc_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [2:0]         alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle MIPS datapath; drives every select and
// write enable. Define MC_MEMREADY_EN to add the mem_ready stall input.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
`ifdef MC_MEMREADY_EN
    input  logic               mem_ready,
`endif
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [2:0]         alucontrol,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic [STATE_W-1:0] state_dbg
);

    state_t state, state_next, dec_state;
    aluop_t aluop;
    logic   mem_rdy;
    logic   pcwrite, branch;
    logic   memwrite_raw, irwrite_raw, regwrite_raw;

`ifdef MC_MEMREADY_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // While reset is high the selects decode as FETCH regardless of state.
    assign dec_state = reset ? S_FETCH : state;

    always_comb begin
        state_next   = S_FETCH;
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        aluop        = ALUOP_ADD;
        pcsrc        = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        case (dec_state)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = mem_rdy;
                pcwrite     = mem_rdy;
                state_next  = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = mem_rdy;
                state_next   = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign memwrite  = memwrite_raw & ~reset;
    assign irwrite   = irwrite_raw & ~reset;
    assign regwrite  = regwrite_raw & ~reset;
    assign pcen      = (pcwrite | (branch & zero)) & ~reset;
    assign state_dbg = STATE_W'(state);

    mc_aludec #(.FUNCT_W(FUNCT_W)) u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level reference model feeding
// an expected-trace queue, checked cycle by cycle by an independent monitor.
module tb_multicycle_controller;

    localparam int W = 19;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
`ifdef MC_MEMREADY_EN
    logic       mem_ready;
`endif
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_dbg;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v, got_v;
    int n_checks = 0;
    int n_bad    = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
`ifdef MC_MEMREADY_EN
        .mem_ready  (mem_ready),
`endif
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model helpers
    function automatic logic [W-1:0] rec(
        input logic [3:0] st, input logic io, mw, irw, rd, m2r, rw, asa,
        input logic [1:0] asb, input logic [2:0] ac, input logic [1:0] ps,
        input logic pe);
        return {st, io, mw, irw, rd, m2r, rw, asa, asb, ac, ps, pe};
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [W-1:0] fetch_rec(input logic ready);
        return rec(4'd0, 0, 0, ready, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, ready);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one instruction starting in FETCH; push its whole expected trace.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int n;
        opcode = op;
        funct  = fn;
        zero   = z;
        exp_q.push_back(fetch_rec(1'b1));
        exp_q.push_back(rec(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0));
        n = 2;
        if (op == 6'b100011) begin
            exp_q.push_back(rec(4'd2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
            exp_q.push_back(rec(4'd3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0));
            exp_q.push_back(rec(4'd4, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0));
            n = 5;
        end else if (op == 6'b101011) begin
            exp_q.push_back(rec(4'd2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
            exp_q.push_back(rec(4'd5, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0));
            n = 4;
        end else if (op == 6'b000000) begin
            exp_q.push_back(rec(4'd6, 0, 0, 0, 0, 0, 0, 1, 2'b00, ref_alu(fn), 2'b00, 0));
            exp_q.push_back(rec(4'd7, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0));
            n = 4;
        end else if (op == 6'b000100) begin
            exp_q.push_back(rec(4'd8, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, z));
            n = 3;
        end else if (op == 6'b001000) begin
            exp_q.push_back(rec(4'd9, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
            exp_q.push_back(rec(4'd10, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0));
            n = 4;
        end else if (op == 6'b000010) begin
            exp_q.push_back(rec(4'd11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 1));
            n = 3;
        end
        wait_cycles(n);
    endtask

    // sw interrupted by reset while computing its address.
    task automatic run_sw_reset();
        opcode = 6'b101011;
        funct  = 6'h00;
        zero   = 1'b1;
        exp_q.push_back(fetch_rec(1'b1));
        exp_q.push_back(rec(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0));
        wait_cycles(2);
        reset = 1'b1;
        exp_q.push_back(rec(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0));
        wait_cycles(1);
        reset = 1'b0;
    endtask

`ifdef MC_MEMREADY_EN
    // lw with a 2-cycle instruction fetch stall and a 3-cycle data read stall.
    task automatic run_lw_stall();
        opcode    = 6'b100011;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) exp_q.push_back(fetch_rec(1'b0));
        wait_cycles(2);
        mem_ready = 1'b1;
        exp_q.push_back(fetch_rec(1'b1));
        exp_q.push_back(rec(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0));
        exp_q.push_back(rec(4'd2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
        wait_cycles(3);
        mem_ready = 1'b0;
        repeat (3) exp_q.push_back(rec(4'd3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0));
        wait_cycles(3);
        mem_ready = 1'b1;
        exp_q.push_back(rec(4'd3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0));
        exp_q.push_back(rec(4'd4, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0));
        wait_cycles(2);
    endtask
`endif

    // Monitor: every cycle with an expectation pending is compared.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            got_v = {state_dbg, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                     alusrca, alusrcb, alucontrol, pcsrc, pcen};
            n_checks++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t op=%b fn=%b got=%b required=%b",
                         $time, opcode, funct, got_v, exp_v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] op_tab[6];
        logic [5:0] fn_tab[5];
        logic [5:0] op, fn;
        op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset  = 1'b1;
        opcode = 6'b100011;
        funct  = 6'h00;
        zero   = 1'b0;
`ifdef MC_MEMREADY_EN
        mem_ready = 1'b1;
`endif
        @(posedge clk);
        #1;
        exp_q.push_back(fetch_rec(1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(6'b100011, 6'h00, 1'b0);
        run_instr(6'b000000, 6'b101010, 1'b0);
        run_instr(6'b000100, 6'h00, 1'b1);
        run_instr(6'b000100, 6'h00, 1'b0);
        run_instr(6'b111111, 6'h00, 1'b1);
        run_sw_reset();
        run_instr(6'b101011, 6'h00, 1'b0);
        run_instr(6'b001000, 6'h00, 1'b1);
        run_instr(6'b000010, 6'h00, 1'b0);
`ifdef MC_MEMREADY_EN
        run_lw_stall();
`endif

        for (int i = 0; i < 80; i++) begin
            int k;
            k = int'($urandom_range(0, 6));
            if (k < 6) begin
                op = op_tab[k];
            end else begin
                op = 6'($urandom_range(0, 63));
                if (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                    op == 6'b000100 || op == 6'b001000 || op == 6'b000010)
                    op = 6'b111111;
            end
            k = int'($urandom_range(0, 5));
            fn = (k < 5) ? fn_tab[k] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
